// File: rtl/sram_read_ctrl.sv
// sram_read_ctrl
// Read sequencer and capture stage that sits in front of the column sense amps.
// A read request moves through five states:
//   IDLE    - waiting for a request
//   PRECH   - bitlines are precharged
//   DEVELOP - the selected wordline is raised so the bitlines can develop
//   SENSE   - the sense amps are strobed
//   RESP    - the captured word is presented on a valid/ready response
//
// Ports
//   clk        single clock; all state changes on the rising edge
//   rst        synchronous, active-high reset
//   req_valid  read request valid
//   req_ready  high only in IDLE
//   req_addr   row address, latched when a request is accepted
//   pc_en      bitline precharge enable
//   wl_sel     one-hot wordline select; all zero when no row is driven
//   sae        sense-amp enable strobe
//   preout     sense-amp outputs, one bit per column
//   rd_valid   response valid
//   rd_ready   response accepted by the consumer
//   rd_data    captured read word
//   rd_err     response belongs to an out-of-range address
//   dbg_state  current FSM state, for observation only
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A request is taken only while req_ready is high (IDLE). Once
// rd_valid rises, it stays high and rd_data/rd_err stay stable until the edge
// where rd_ready is seen high.
module sram_read_ctrl #(
  parameter int COLS       = 16,
  parameter int ROWS       = 16,
  parameter int ADDR_W     = 4,
  parameter int PRE_CYCLES = 2,
  parameter int DEV_CYCLES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  output logic              pc_en,
  output logic [ROWS-1:0]   wl_sel,
  output logic              sae,
  input  logic [COLS-1:0]   preout,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [COLS-1:0]   rd_data,
  output logic              rd_err,
  output logic [2:0]        dbg_state
);

  localparam int MAX_CYC = (PRE_CYCLES > DEV_CYCLES) ? PRE_CYCLES : DEV_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_PRECH   = 3'd1,
    S_DEVELOP = 3'd2,
    S_SENSE   = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [COLS-1:0]   data_q, data_d;
  logic              err_q, err_d;

  // Registered copies of the state-decoded outputs. They are computed from
  // the next state, so each one changes on the same edge as the state does,
  // and no input ever reaches an output without going through a flop.
  logic              req_ready_q, req_ready_d;
  logic              pc_en_q, pc_en_d;
  logic [ROWS-1:0]   wl_sel_q, wl_sel_d;
  logic              sae_q, sae_d;
  logic              rd_valid_q, rd_valid_d;
  logic              wl_active;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    data_d  = data_q;
    err_d   = err_q;

    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          addr_d = req_addr;
          if (32'(req_addr) < ROWS) begin
            state_d = S_PRECH;
            cnt_d   = CNT_W'(PRE_CYCLES);
          end else begin
            // Out-of-range rows never touch the array: answer at once.
            state_d = S_RESP;
            data_d  = '0;
            err_d   = 1'b1;
          end
        end
      end
      S_PRECH: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DEVELOP;
          cnt_d   = CNT_W'(DEV_CYCLES);
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_DEVELOP: begin
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_SENSE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_SENSE: begin
        // Sense amps have been strobed for a full cycle; capture at the edge.
        data_d  = preout;
        err_d   = 1'b0;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (rd_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    req_ready_d = (state_d == S_IDLE);
    pc_en_d     = (state_d == S_PRECH);
    sae_d       = (state_d == S_SENSE);
    rd_valid_d  = (state_d == S_RESP);

    // The wordline stays up through SENSE so the bitlines hold their split.
    wl_active = (state_d == S_DEVELOP) || (state_d == S_SENSE);
    wl_sel_d  = '0;
    for (int r = 0; r < ROWS; r++) begin
      wl_sel_d[r] = wl_active && (32'(addr_d) == r);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      data_q      <= '0;
      err_q       <= 1'b0;
      req_ready_q <= 1'b1;
      pc_en_q     <= 1'b0;
      wl_sel_q    <= '0;
      sae_q       <= 1'b0;
      rd_valid_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      err_q       <= err_d;
      req_ready_q <= req_ready_d;
      pc_en_q     <= pc_en_d;
      wl_sel_q    <= wl_sel_d;
      sae_q       <= sae_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  assign req_ready = req_ready_q;
  assign pc_en     = pc_en_q;
  assign wl_sel    = wl_sel_q;
  assign sae       = sae_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = data_q;
  assign rd_err    = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sram_read_ctrl.sv
// Bench for sram_read_ctrl. Two instances share clock and reset:
//   u_dut_a - default parameters (16 rows)
//   u_dut_b - ROWS=12, so addresses 12..15 are out of range
// A select bit steers the stimulus to one instance and its outputs to the
// checker. The other instance sits idle with req_valid low.
module tb_sram_read_ctrl;

  localparam int PRE = 2;
  localparam int DEV = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // shared stimulus
  logic        sel = 1'b0;
  logic        t_req_valid = 1'b0;
  logic [3:0]  t_req_addr = '0;
  logic [15:0] t_preout = '0;
  logic        t_rd_ready = 1'b0;

  // instance A
  logic        a_req_valid, a_req_ready, a_pc_en, a_sae, a_rd_valid, a_rd_err;
  logic [15:0] a_wl_sel, a_rd_data;
  logic [2:0]  a_dbg_state;
  // instance B
  logic        b_req_valid, b_req_ready, b_pc_en, b_sae, b_rd_valid, b_rd_err;
  logic [11:0] b_wl_sel;
  logic [15:0] b_rd_data;
  logic [2:0]  b_dbg_state;

  assign a_req_valid = ~sel & t_req_valid;
  assign b_req_valid = sel & t_req_valid;

  sram_read_ctrl u_dut_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_addr(t_req_addr),
    .pc_en(a_pc_en), .wl_sel(a_wl_sel), .sae(a_sae), .preout(t_preout),
    .rd_valid(a_rd_valid), .rd_ready(t_rd_ready & ~sel),
    .rd_data(a_rd_data), .rd_err(a_rd_err), .dbg_state(a_dbg_state)
  );

  sram_read_ctrl #(.ROWS(12)) u_dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(t_req_addr),
    .pc_en(b_pc_en), .wl_sel(b_wl_sel), .sae(b_sae), .preout(t_preout),
    .rd_valid(b_rd_valid), .rd_ready(t_rd_ready & sel),
    .rd_data(b_rd_data), .rd_err(b_rd_err), .dbg_state(b_dbg_state)
  );

  // outputs of the selected instance
  logic        o_req_ready, o_pc_en, o_sae, o_rd_valid, o_rd_err;
  logic [15:0] o_wl_sel, o_rd_data;
  assign o_req_ready = sel ? b_req_ready : a_req_ready;
  assign o_pc_en     = sel ? b_pc_en : a_pc_en;
  assign o_wl_sel    = sel ? {4'b0, b_wl_sel} : a_wl_sel;
  assign o_sae       = sel ? b_sae : a_sae;
  assign o_rd_valid  = sel ? b_rd_valid : a_rd_valid;
  assign o_rd_data   = sel ? b_rd_data : a_rd_data;
  assign o_rd_err    = sel ? b_rd_err : a_rd_err;

  int n_tests = 0;
  int n_fail  = 0;

  // scoreboard: words expected on the response side, oldest first
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Array-level safety rules, checked on both instances every cycle.
  always @(negedge clk) begin
    if (!rst) begin
      chk("a_pc_wl_overlap", 32'(a_pc_en && (a_wl_sel != 0)), 0);
      chk("a_wl_onehot", 32'($onehot0(a_wl_sel)), 1);
      chk("a_sae_needs_wl", 32'(a_sae && (a_wl_sel == 0)), 0);
      chk("b_pc_wl_overlap", 32'(b_pc_en && (b_wl_sel != 0)), 0);
      chk("b_wl_onehot", 32'($onehot0(b_wl_sel)), 1);
      chk("b_sae_needs_wl", 32'(b_sae && (b_wl_sel == 0)), 0);
    end
  end

  // Behavioural reference: in-range rows respond after precharge, develop and
  // one sense cycle plus one cycle to enter RESP; others respond immediately.
  function automatic void ref_read(input int addr, input int rows, input logic [15:0] word,
                                   output logic [15:0] data, output logic err, output int lat);
    if (addr < rows) begin
      data = word;
      err  = 1'b0;
      lat  = PRE + DEV + 2;
    end else begin
      data = '0;
      err  = 1'b1;
      lat  = 1;
    end
  endfunction

  // Runs one read on the selected instance. Called with the DUT in IDLE, just
  // after a rising edge; returns just after the response handshake edge.
  // Cycle k counts periods after the accept edge (k=1 is the first).
  task automatic run_read(input logic s, input logic [3:0] addr, input logic [15:0] word,
                          input int hold, input bit keep, input logic [15:0] exp_data,
                          input logic exp_err, input int exp_lat);
    int last;
    bit inr;
    logic [15:0] wl_exp;
    sel = s;
    inr = !exp_err;
    last = exp_lat + hold;
    t_req_valid = 1'b1;
    t_req_addr  = addr;
    t_preout    = 16'($urandom);
    t_rd_ready  = 1'($urandom_range(0, 1));
    @(negedge clk);
    chk("idle_req_ready", 32'(o_req_ready), 1);
    chk("idle_rd_valid", 32'(o_rd_valid), 0);
    chk("idle_pc_en", 32'(o_pc_en), 0);
    @(posedge clk);
    #1;
    exp_q.push_back(exp_data);
    for (int k = 1; k <= last; k++) begin
      // req_valid during the read must be ignored
      t_req_valid = keep ? 1'b1 : 1'($urandom_range(0, 1));
      t_req_addr  = 4'($urandom);
      // preout only matters in the sense cycle
      t_preout    = (inr && k == exp_lat - 1) ? word : 16'($urandom);
      if (k == last)         t_rd_ready = 1'b1;
      else if (k < exp_lat)  t_rd_ready = 1'($urandom_range(0, 1));
      else                   t_rd_ready = 1'b0;
      @(negedge clk);
      wl_exp = (inr && k > PRE && k <= exp_lat - 1) ? (16'd1 << addr) : 16'd0;
      chk("pc_en", 32'(o_pc_en), 32'(inr && k <= PRE));
      chk("wl_sel", 32'(o_wl_sel), 32'(wl_exp));
      chk("sae", 32'(o_sae), 32'(inr && k == exp_lat - 1));
      chk("rd_valid", 32'(o_rd_valid), 32'(k >= exp_lat));
      chk("req_ready", 32'(o_req_ready), 0);
      if (k >= exp_lat) begin
        chk("rd_data", 32'(o_rd_data), 32'(exp_q[0]));
        chk("rd_err", 32'(o_rd_err), 32'(exp_err));
      end
      @(posedge clk);
      #1;
    end
    void'(exp_q.pop_front());
    t_rd_ready  = 1'b0;
    t_req_valid = keep ? 1'b1 : 1'b0;
  endtask

  typedef struct {
    logic        sel;
    logic [3:0]  addr;
    logic [15:0] word;
    int          hold;
    bit          keep;
    logic [15:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[8];

  initial begin
    logic [15:0] rdata;
    logic        rerr;
    int          rlat;
    logic        rs;
    logic [3:0]  raddr;
    logic [15:0] rword;

    //                sel  addr  word      hold keep exp_data  err  lat
    vecs[0] = '{1'b0, 4'd5,  16'hA5C3, 0,  1'b0, 16'hA5C3, 1'b0, 7};
    vecs[1] = '{1'b0, 4'd15, 16'h3C5A, 10, 1'b0, 16'h3C5A, 1'b0, 7};
    vecs[2] = '{1'b1, 4'd13, 16'hFFFF, 0,  1'b0, 16'h0000, 1'b1, 1};
    vecs[3] = '{1'b1, 4'd11, 16'h1234, 1,  1'b0, 16'h1234, 1'b0, 7};
    vecs[4] = '{1'b1, 4'd12, 16'hBEEF, 2,  1'b0, 16'h0000, 1'b1, 1};
    vecs[5] = '{1'b1, 4'd0,  16'h7E01, 0,  1'b0, 16'h7E01, 1'b0, 7};
    vecs[6] = '{1'b0, 4'd0,  16'h0001, 0,  1'b1, 16'h0001, 1'b0, 7};
    vecs[7] = '{1'b0, 4'd1,  16'h8000, 0,  1'b0, 16'h8000, 1'b0, 7};

    // reset state of both instances
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_a_req_ready", 32'(a_req_ready), 1);
    chk("rst_a_pc_en", 32'(a_pc_en), 0);
    chk("rst_a_wl_sel", 32'(a_wl_sel), 0);
    chk("rst_a_sae", 32'(a_sae), 0);
    chk("rst_a_rd_valid", 32'(a_rd_valid), 0);
    chk("rst_a_rd_data", 32'(a_rd_data), 0);
    chk("rst_a_rd_err", 32'(a_rd_err), 0);
    chk("rst_b_req_ready", 32'(b_req_ready), 1);
    chk("rst_b_wl_sel", 32'(b_wl_sel), 0);
    chk("rst_b_rd_valid", 32'(b_rd_valid), 0);
    @(posedge clk);
    #1;

    // directed vectors; rows 6 and 7 run back to back with req_valid held
    for (int i = 0; i < 8; i++) begin
      run_read(vecs[i].sel, vecs[i].addr, vecs[i].word, vecs[i].hold, vecs[i].keep,
               vecs[i].exp_data, vecs[i].exp_err, vecs[i].exp_lat);
    end

    // reset in the middle of DEVELOP for row 3
    sel = 1'b0;
    t_req_valid = 1'b1;
    t_req_addr  = 4'd3;
    @(posedge clk);
    #1;
    t_req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_wl_sel", 32'(a_wl_sel), 32'h0008);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_wl_sel", 32'(a_wl_sel), 0);
    chk("post_rst_req_ready", 32'(a_req_ready), 1);
    chk("post_rst_rd_valid", 32'(a_rd_valid), 0);
    chk("post_rst_pc_en", 32'(a_pc_en), 0);
    chk("post_rst_rd_data", 32'(a_rd_data), 0);
    @(posedge clk);
    #1;
    run_read(1'b0, 4'd3, 16'h5A5A, 0, 1'b0, 16'h5A5A, 1'b0, 7);

    // randomized reads against the reference model
    for (int i = 0; i < 30; i++) begin
      rs    = 1'($urandom_range(0, 1));
      raddr = 4'($urandom_range(0, 15));
      rword = 16'($urandom);
      ref_read(int'(raddr), rs ? 12 : 16, rword, rdata, rerr, rlat);
      run_read(rs, raddr, rword, $urandom_range(0, 3), 1'($urandom_range(0, 1)),
               rdata, rerr, rlat);
      t_req_valid = 1'b0;
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        chk("gap_req_ready", 32'(o_req_ready), 1);
        chk("gap_rd_valid", 32'(o_rd_valid), 0);
        @(posedge clk);
        #1;
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
